lpc_record_buffer: RTL and testbench



---
 rtl/lpc_record_buffer.sv | 150 +++++++++++++++
 tb/tb_lpc_record_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_record_buffer.sv
// lpc_record_buffer: captures completed LPC transactions into a record FIFO
// and streams each record as six bytes over a valid/ready byte port.
module lpc_record_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                      lpc_clock,
  input  logic                      lpc_reset,
  input  logic [3:0]                in_cyctype_dir,
  input  logic [31:0]               in_addr,
  input  logic [7:0]                in_data,
  input  logic                      in_strobe,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic          r_strobe_q;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [44:0]   r_mem [DEPTH];
  logic          r_pend;
  logic          r_ovf;
  logic [0:0]    r_state;
  logic [2:0]    r_idx;
  logic [7:0]    r_out_byte;
  logic          r_out_valid;

  logic          w_cap;
  logic          w_full;
  logic          w_empty;
  logic          w_hs;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_more;
  logic [AW:0]   w_rd_nx;
  logic [44:0]   w_head;
  logic [44:0]   w_next;

  function automatic logic [7:0] f_byte(
    input logic [44:0] rec,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = {rec[43:40], 3'b000, rec[44]};
      3'd1:    b = rec[39:32];
      3'd2:    b = rec[31:24];
      3'd3:    b = rec[23:16];
      3'd4:    b = rec[15:8];
      default: b = rec[7:0];
    endcase
    return b;
  endfunction

  assign w_cap   = in_strobe && !r_strobe_q;
  assign w_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign w_rd_nx = r_rd_ptr + {{AW{1'b0}}, 1'b1};
  assign w_more  = r_wr_ptr != w_rd_nx;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_next  = r_mem[w_rd_nx[AW-1:0]];
  assign w_hs    = r_out_valid && out_ready;
  assign w_pop   = w_hs && (r_idx == 3'd5);
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;

  assign out_byte   = r_out_byte;
  assign out_valid  = r_out_valid;
  assign fifo_count = r_wr_ptr - r_rd_ptr;
  assign overflow   = r_ovf;

  always_ff @(posedge lpc_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_pend, in_cyctype_dir, in_addr, in_data};
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      r_strobe_q <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pend     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_strobe_q <= in_strobe;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nx;
      end
      if (w_push) begin
        r_pend <= 1'b0;
      end else if (w_drop) begin
        r_pend <= 1'b1;
        r_ovf  <= 1'b1;
      end
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state     <= S_SEND;
            r_out_valid <= 1'b1;
            r_out_byte  <= f_byte(w_head, 3'd0);
            r_idx       <= 3'd0;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_idx != 3'd5) begin
              r_idx      <= r_idx + 3'd1;
              r_out_byte <= f_byte(w_head, r_idx + 3'd1);
            end else if (w_more) begin
              // Next record already resident: chain without a bubble
              r_idx      <= 3'd0;
              r_out_byte <= f_byte(w_next, 3'd0);
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_idx       <= 3'd0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_record_buffer.sv
// tb_lpc_record_buffer: directed and random checks of the record buffer
// against a queue-based model of records and the six-byte stream.
module tb_lpc_record_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic        ready = 1'b0;
  logic [3:0]  cyc = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [7:0]  data = 8'h0;
  logic [7:0]  ob;
  logic        ov;
  logic [4:0]  cnt;
  logic        ovf;

  int total = 0;
  int bad = 0;

  logic [44:0] q[$];
  int sent = 0;
  bit pend = 0;
  bit movf = 0;
  bit prevs = 0;

  lpc_record_buffer #(.DEPTH(DEPTH)) dut (
    .lpc_clock      (clk),
    .lpc_reset      (rst_n),
    .in_cyctype_dir (cyc),
    .in_addr        (addr),
    .in_data        (data),
    .in_strobe      (strobe),
    .out_byte       (ob),
    .out_valid      (ov),
    .out_ready      (ready),
    .fifo_count     (cnt),
    .overflow       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [44:0] r, input int i);
    logic        lost;
    logic [3:0]  c;
    logic [31:0] a;
    logic [7:0]  d;
    lost = r[44];
    c = r[43:40];
    a = r[39:8];
    d = r[7:0];
    if (i == 0) return {c, 3'b000, lost};
    if (i == 5) return d;
    return 8'(a >> (8 * (4 - i)));
  endfunction

  task automatic step(input bit s, input bit r);
    bit pv, cap, hs, full, pop;
    strobe = s;
    ready = r;
    pv = ov;
    cap = s && !prevs;
    @(posedge clk);
    #1;
    hs = pv && r;
    full = q.size() == DEPTH;
    pop = 0;
    if (hs && q.size() > 0) begin
      if (sent == 5) begin
        pop = 1;
        void'(q.pop_front());
        sent = 0;
      end else begin
        sent++;
      end
    end
    if (cap) begin
      if (!full || pop) begin
        q.push_back({pend, cyc, addr, data});
        pend = 0;
      end else begin
        pend = 1;
        movf = 1;
      end
    end
    prevs = s;
    chk("count", cnt, q.size());
    chk("overflow", ovf, movf);
    if (q.size() == 0) chk("idle_valid", ov, 0);
    if (ov && q.size() > 0) chk("byte", ob, mbyte(q[0], sent));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    strobe = 1'b0;
    ready = 1'b0;
    q.delete();
    sent = 0;
    pend = 0;
    movf = 0;
    prevs = 0;
    #2;
    chk("rst_valid", ov, 0);
    chk("rst_byte", ob, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic capture(input bit r);
    cyc = 4'($urandom);
    addr = $urandom;
    data = 8'($urandom);
    step(1, r);
    step(0, r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      step(0, 1);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ov && n < 8) begin
      step(0, 1);
      n++;
    end
    chk(tag, ov, 1);
  endtask

  logic [7:0] t1_exp [6];
  int pat [4];

  initial begin
    t1_exp[0] = 8'h20; t1_exp[1] = 8'h00; t1_exp[2] = 8'h00;
    t1_exp[3] = 8'h00; t1_exp[4] = 8'h80; t1_exp[5] = 8'h5A;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    @(posedge clk);
    #1;
    do_reset();

    // single record latency and byte order
    cyc = 4'h2;
    addr = 32'h0000_0080;
    data = 8'h5A;
    step(1, 1);
    chk("t1_cnt", cnt, 1);
    chk("t1_lat_v0", ov, 0);
    step(0, 1);
    chk("t1_v", ov, 1);
    chk("t1_b0", ob, t1_exp[0]);
    for (int i = 1; i < 6; i++) begin
      step(0, 1);
      chk("t1_vi", ov, 1);
      chk("t1_bi", ob, t1_exp[i]);
    end
    step(0, 1);
    chk("t1_end_v", ov, 0);
    chk("t1_end_cnt", cnt, 0);

    // backpressure
    capture(0);
    for (int i = 0; i < 28; i++) step(0, pat[i % 4] != 0);
    drain();

    // overflow and lost flag
    for (int i = 0; i < 18; i++) capture(0);
    chk("ov_cnt", cnt, 16);
    chk("ov_flag", ovf, 1);
    drain();
    capture(1);
    wait_valid("ov_lost_v");
    chk("ov_lost1", ob[0], 1);
    drain();
    capture(1);
    wait_valid("ov_lost0_v");
    chk("ov_lost0", ob[0], 0);
    drain();

    // full with simultaneous pop
    do_reset();
    for (int i = 0; i < 16; i++) capture(0);
    chk("fp_full", cnt, 16);
    for (int n = 0; sent != 5 && n < 20; n++) step(0, 1);
    cyc = 4'hA;
    addr = 32'hDEAD_BEEF;
    data = 8'h3C;
    step(1, 1);
    chk("fp_cnt", cnt, 16);
    chk("fp_ovf", ovf, 0);
    step(0, 1);
    drain();

    // strobe held high
    cyc = 4'h5;
    addr = 32'h1234_5678;
    data = 8'h9A;
    for (int i = 0; i < 5; i++) step(1, 0);
    step(0, 0);
    chk("hold_cnt", cnt, 1);
    drain();

    // two strobes, back-to-back stream
    cyc = 4'h1;
    step(1, 1);
    step(0, 1);
    chk("b2b_v0", ov, 1);
    cyc = 4'h7;
    addr = 32'hCAFE_0001;
    step(1, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1);
      chk("b2b_gap", ov, 1);
    end
    step(0, 1);
    chk("b2b_end", ov, 0);

    // async reset mid-record
    for (int i = 0; i < 3; i++) capture(0);
    step(0, 1);
    step(0, 1);
    chk("ar_pre_cnt", cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", ov, 0);
    chk("ar_cnt", cnt, 0);
    q.delete();
    sent = 0;
    pend = 0;
    movf = 0;
    prevs = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 1);

    // random traffic, two ready densities
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        if (!strobe) begin
          cyc = 4'($urandom);
          addr = $urandom;
          data = 8'($urandom);
        end
        step($urandom_range(0, 2) == 0,
             ph == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 5) == 0);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
